// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: CPU, secondary and data-memory signals of the dm port arbiter
interface dm_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        sec_valid;
  logic        sec_ready;
  logic        sec_we;
  logic [6:0]  sec_addr;
  logic [31:0] sec_wdata;
  logic [2:0]  sec_type;
  logic        sec_rvalid;
  logic [31:0] sec_rdata;
  logic        dm_wr;
  logic [6:0]  dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic [31:0] dm_dout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    output cpu_rdata, cpu_stall,
    input  sec_valid, sec_we, sec_addr, sec_wdata, sec_type,
    output sec_ready, sec_rvalid, sec_rdata,
    output dm_wr, dm_addr, dm_din, dm_type,
    input  dm_dout
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    input  cpu_rdata, cpu_stall,
    output sec_valid, sec_we, sec_addr, sec_wdata, sec_type,
    input  sec_ready, sec_rvalid, sec_rdata,
    input  dm_wr, dm_addr, dm_din, dm_type,
    output dm_dout
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the dm port between CPU (priority) and a secondary master.
// Optional alignment checking with align_err output when DM_ALIGN_CHECK_EN is defined.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int SEC_BURST    = 4
) (
  input  logic clk,
  input  logic rstn,
  dm_port_arbiter_if.slave bus
`ifdef DM_ALIGN_CHECK_EN
  ,
  output logic align_err
`endif
);
  typedef enum logic {S_CPU, S_SEC} state_t;
  state_t      state, state_n;
  logic [7:0]  starve_cnt;
  logic [3:0]  burst_cnt;
  logic        own_sec, mis, req, accept, starve_hit, burst_end;
  logic        sec_rvalid_q;
  logic [31:0] sec_rdata_q;
  assign own_sec    = state == S_SEC;
  assign bus.dm_addr = own_sec ? bus.sec_addr  : bus.cpu_addr;
  assign bus.dm_type = own_sec ? bus.sec_type  : bus.cpu_type;
  assign bus.dm_din  = own_sec ? bus.sec_wdata : bus.cpu_wdata;
  assign req        = own_sec ? bus.sec_valid : bus.cpu_req;
`ifdef DM_ALIGN_CHECK_EN
  assign mis = (bus.dm_type[1:0] == 2'b10 && bus.dm_addr[1:0] != 2'b00) ||
               (bus.dm_type[1:0] == 2'b01 && bus.dm_addr[0]);
`else
  assign mis = 1'b0;
`endif
  assign bus.dm_wr     = (own_sec ? bus.sec_valid & bus.sec_we : bus.cpu_req & bus.cpu_we) & ~mis;
  assign bus.sec_ready = own_sec & bus.sec_valid;
  assign bus.cpu_stall = own_sec & bus.cpu_req;
  assign bus.cpu_rdata = bus.dm_dout;
  assign bus.sec_rvalid = sec_rvalid_q;
  assign bus.sec_rdata  = sec_rdata_q;
  assign accept     = bus.sec_valid & bus.sec_ready;
  assign starve_hit = starve_cnt == 8'(STARVE_LIMIT - 1);
  assign burst_end  = burst_cnt == 4'(SEC_BURST - 1);
  always_comb begin
    state_n = state;
    if (!own_sec)
      state_n = (bus.sec_valid && (!bus.cpu_req || starve_hit)) ? S_SEC : S_CPU;
    else
      state_n = (!bus.sec_valid || (accept && (bus.cpu_req || burst_end))) ? S_CPU : S_SEC;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_CPU;
      starve_cnt   <= '0;
      burst_cnt    <= '0;
      sec_rvalid_q <= 1'b0;
      sec_rdata_q  <= '0;
    end else begin
      state <= state_n;
      if (!own_sec)
        starve_cnt <= (!bus.sec_valid || state_n == S_SEC) ? 8'd0 :
                      (bus.cpu_req && !starve_hit) ? starve_cnt + 8'd1 : starve_cnt;
      if (!own_sec && state_n == S_SEC)
        burst_cnt <= '0;
      else if (accept)
        burst_cnt <= burst_cnt + 4'd1;
      sec_rvalid_q <= accept & ~bus.sec_we;
      if (accept && !bus.sec_we)
        sec_rdata_q <= mis ? 32'h0 : bus.dm_dout;
    end
  end
`ifdef DM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) align_err <= 1'b0;
    else       align_err <= req & mis;
  end
`else
  logic unused_req;
  assign unused_req = req;
`endif
endmodule
